// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the iterative M-extension divide unit.
package rv32_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  localparam int DIV_STEPS = 32;

endpackage

// File: rtl/div_unit_if.sv
// Issue-side bundle of the divide unit: operands and request in, result and GPR write out.
interface div_unit_if #(parameter int XLEN = 32);

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_add;
  logic            write_en;

  modport master (
    output start, op, operand_a, operand_b, rd_in, flush,
    input  busy, done, result, rd_add, write_en
  );

  modport slave (
    input  start, op, operand_a, operand_b, rd_in, flush,
    output busy, done, result, rd_add, write_en
  );

endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): 32-step restoring division on magnitudes,
// with divide-by-zero and signed overflow resolved in the accept cycle.
module div_unit
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_t        r_state;
  div_state_t        w_nextState;
  logic [4:0]        r_count;
  logic [2*XLEN-1:0] r_shift;
  logic [XLEN-1:0]   r_divisor;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rdPend;
  logic [4:0]        r_rdAdd;
  logic              r_selRem;
  logic              r_negQuo;
  logic              r_negRem;

  div_op_t           w_op;
  logic              w_accept;
  logic              w_isSigned;
  logic              w_divZero;
  logic              w_overflow;
  logic              w_special;
  logic              w_lastStep;
  logic [XLEN-1:0]   w_magA;
  logic [XLEN-1:0]   w_magB;
  logic [XLEN-1:0]   w_specialResult;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fixed;
  logic [XLEN:0]     w_trial;

  always_comb begin
    w_op       = div_op_t'(bus.op);
    w_accept   = (r_state == IDLE) && bus.start && !bus.flush;
    w_isSigned = (w_op == DIV) || (w_op == REM);
    w_divZero  = (bus.operand_b == '0);
    w_overflow = w_isSigned && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                 && (bus.operand_b == '1);
    w_special  = w_divZero || w_overflow;
    w_magA     = (w_isSigned && bus.operand_a[XLEN-1]) ? -bus.operand_a : bus.operand_a;
    w_magB     = (w_isSigned && bus.operand_b[XLEN-1]) ? -bus.operand_b : bus.operand_b;
    if (w_divZero)
      w_specialResult = bus.op[1] ? bus.operand_a : '1;
    else
      w_specialResult = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    // Partial remainder is 33 bits wide after the shift, so the trial spans r_shift[63:31].
    w_trial    = r_shift[2*XLEN-1:XLEN-1] - {1'b0, r_divisor};
    w_quo      = r_negQuo ? -r_shift[XLEN-1:0] : r_shift[XLEN-1:0];
    w_rem      = r_negRem ? -r_shift[2*XLEN-1:XLEN] : r_shift[2*XLEN-1:XLEN];
    w_fixed    = r_selRem ? w_rem : w_quo;
    w_lastStep = (r_count == 5'(DIV_STEPS - 1));
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept) w_nextState = w_special ? DONE : CALC;
      CALC: begin
        if (bus.flush)       w_nextState = IDLE;
        else if (w_lastStep) w_nextState = FIX;
      end
      FIX:     w_nextState = bus.flush ? IDLE : DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= '0;
      r_shift   <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_rdPend  <= '0;
      r_rdAdd   <= '0;
      r_selRem  <= 1'b0;
      r_negQuo  <= 1'b0;
      r_negRem  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_count   <= '0;
            r_shift   <= {{XLEN{1'b0}}, w_magA};
            r_divisor <= w_magB;
            r_rdPend  <= bus.rd_in;
            r_selRem  <= bus.op[1];
            r_negQuo  <= w_isSigned && (bus.operand_a[XLEN-1] ^ bus.operand_b[XLEN-1]);
            r_negRem  <= w_isSigned && bus.operand_a[XLEN-1];
            if (w_special) begin
              r_result <= w_specialResult;
              r_rdAdd  <= bus.rd_in;
            end
          end
        end
        CALC: begin
          if (!bus.flush) begin
            r_count <= r_count + 5'd1;
            if (!w_trial[XLEN])
              r_shift <= {w_trial[XLEN-1:0], r_shift[XLEN-2:0], 1'b1};
            else
              r_shift <= {r_shift[2*XLEN-2:0], 1'b0};
          end
        end
        FIX: begin
          // Visible outputs only change when the result is actually delivered.
          if (!bus.flush) begin
            r_result <= w_fixed;
            r_rdAdd  <= r_rdPend;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DONE);
  assign bus.write_en = (r_state == DONE) && !bus.flush;
  assign bus.result   = r_result;
  assign bus.rd_add   = r_rdAdd;

endmodule
